// File: rtl/MemState_pkg.sv
// -----------------------------------------------------------------------------
// MemState_pkg
// Shared types and constants for the multi-cycle memory responder.
//   MemState_t  : responder FSM states (IDLE, WAIT, RESP)
//   WORD_BYTES  : bytes per memory word
//   BYTE_OFS_W  : number of byte-offset address bits below the word index
// -----------------------------------------------------------------------------
package MemState_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } MemState_t;

   localparam int WORD_BYTES = 4;
   localparam int BYTE_OFS_W = $clog2(WORD_BYTES);

endpackage

// File: rtl/mem_word_array.sv
// -----------------------------------------------------------------------------
// mem_word_array
// Single-port, 2**IDX_W x DATA_W RAM with a synchronous write and a
// registered read. The read register only updates when i_Re is high, so the
// last read word stays on o_RData until the next read.
// Ports:
//   i_Clk    clock
//   i_We     write enable (writes i_WData to word i_Idx)
//   i_Re     read enable  (registers word i_Idx onto o_RData)
//   i_Idx    word index
//   i_WData  write data
//   o_RData  registered read data
// -----------------------------------------------------------------------------
module mem_word_array
   import MemState_pkg::*;
#(
   parameter int IDX_W  = 10,
   parameter int DATA_W = 8 * WORD_BYTES
) (
   input  logic              i_Clk,
   input  logic              i_We,
   input  logic              i_Re,
   input  logic [IDX_W-1:0]  i_Idx,
   input  logic [DATA_W-1:0] i_WData,
   output logic [DATA_W-1:0] o_RData
);

   logic [DATA_W-1:0] mem [2**IDX_W];

   always_ff @(posedge i_Clk) begin
      if (i_We) begin
         mem[i_Idx] <= i_WData;
      end
      if (i_Re) begin
         o_RData <= mem[i_Idx];
      end
   end

endmodule

// File: rtl/multicycle_mem_responder.sv
// -----------------------------------------------------------------------------
// multicycle_mem_responder
// Unified instruction/data memory responder for the multi-cycle RISC-V core.
// A request is accepted in IDLE or RESP, held for LATENCY-1 wait cycles, then
// the access is performed and o_Ready pulses for one cycle. Holding i_Req high
// in RESP chains the next access with no idle bubble.
//
// Parameters:
//   ADDR_W   byte-address bits decoded; depth = 2**(ADDR_W-2) words
//   LATENCY  cycles from request acceptance to o_Ready (1..15)
// Ports:
//   i_Clk    clock (posedge)
//   i_Reset  synchronous active-high reset
//   i_Req    access request (sampled in IDLE/RESP only)
//   i_We     1 = store word, 0 = load/fetch word
//   i_Addr   byte address
//   i_WData  store data
//   o_RData  load data, held until the next load completes
//   o_Ready  one-cycle completion pulse
//   o_Busy   high while in WAIT
//   o_Fault  access fault, qualified by o_Ready
//
// Build option: define MEM_ACCESS_FAULT_EN to flag misaligned or out-of-range
// addresses (store suppressed, o_RData forced to 0). Without it, o_Fault is 0
// and those address bits are simply ignored (upper addresses alias).
// -----------------------------------------------------------------------------
module multicycle_mem_responder
   import MemState_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int LATENCY = 2
) (
   input  logic        i_Clk,
   input  logic        i_Reset,
   input  logic        i_Req,
   input  logic        i_We,
   input  logic [31:0] i_Addr,
   input  logic [31:0] i_WData,
   output logic [31:0] o_RData,
   output logic        o_Ready,
   output logic        o_Busy,
   output logic        o_Fault
);

   localparam int              IDX_W    = ADDR_W - BYTE_OFS_W;
   localparam int              CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   MemState_t          state;
   logic [CNT_W-1:0]   cnt;
   logic               we_q;
   logic [IDX_W-1:0]   idx_q;
   logic [31:0]        wdata_q;
   logic               fault_q;
   logic               rd_zero_q;   // forces o_RData to 0 after reset or a faulted access

   logic               req_fault;
   logic               accept;
   logic               do_access;
   logic               ram_we;
   logic               ram_re;
   logic [31:0]        ram_rdata;

`ifdef MEM_ACCESS_FAULT_EN
   assign req_fault = (i_Addr[BYTE_OFS_W-1:0] != '0) || (i_Addr[31:ADDR_W] != '0);
`else
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_Addr[31:ADDR_W], i_Addr[BYTE_OFS_W-1:0]};
   assign req_fault        = 1'b0;
`endif

   assign accept    = i_Req && ((state == IDLE) || (state == RESP));
   // Reset on the commit edge must win, so the RAM enables are gated by it.
   assign do_access = (state == WAIT) && (cnt == '0) && !i_Reset;
   assign ram_we    = do_access &&  we_q && !fault_q;
   assign ram_re    = do_access && !we_q && !fault_q;

   assign o_RData   = rd_zero_q ? '0 : ram_rdata;

   // Request capture: data path, not reset.
   always_ff @(posedge i_Clk) begin
      if (accept) begin
         we_q    <= i_We;
         idx_q   <= i_Addr[ADDR_W-1:BYTE_OFS_W];
         wdata_q <= i_WData;
         fault_q <= req_fault;
      end
   end

   // Control FSM with registered outputs.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state     <= IDLE;
         cnt       <= '0;
         o_Ready   <= 1'b0;
         o_Busy    <= 1'b0;
         o_Fault   <= 1'b0;
         rd_zero_q <= 1'b1;
      end else begin
         o_Ready <= 1'b0;
         o_Fault <= 1'b0;
         case (state)
            IDLE, RESP: begin
               if (i_Req) begin
                  state  <= WAIT;
                  cnt    <= CNT_LOAD;
                  o_Busy <= 1'b1;
               end else begin
                  state  <= IDLE;
                  o_Busy <= 1'b0;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state   <= RESP;
                  o_Busy  <= 1'b0;
                  o_Ready <= 1'b1;
                  o_Fault <= fault_q;
                  // A clean store leaves the previous load data visible.
                  if (fault_q) begin
                     rd_zero_q <= 1'b1;
                  end else if (!we_q) begin
                     rd_zero_q <= 1'b0;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               o_Busy <= 1'b0;
            end
         endcase
      end
   end

   mem_word_array #(
      .IDX_W  (IDX_W),
      .DATA_W (32)
   ) u_mem (
      .i_Clk   (i_Clk),
      .i_We    (ram_we),
      .i_Re    (ram_re),
      .i_Idx   (idx_q),
      .i_WData (wdata_q),
      .o_RData (ram_rdata)
   );

endmodule
